// File: rtl/bus_interconnect_n.sv
// bus_interconnect_n: single-master to N-slave bus bridge with address decode, ack timeout and error response
module bus_interconnect_n #(
  parameter int                      NUM_SLAVES = 2,
  parameter logic [4*NUM_SLAVES-1:0] SLAVE_BASE = {4'h8, 4'h0},
  parameter int                      TIMEOUT    = 16,
  parameter logic [31:0]             ERR_DATA   = 32'hDEAD_BEEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     proc_rd_en_i,
  input  logic                     proc_wr_en_i,
  input  logic [31:0]              proc_addr_i,
  input  logic [31:0]              proc_data_i,
  output logic [31:0]              proc_data_o,
  output logic                     proc_ack_o,
  output logic                     proc_err_o,
  output logic                     proc_busy_o,
  output logic [NUM_SLAVES-1:0]    slv_rd_en_o,
  output logic [NUM_SLAVES-1:0]    slv_wr_en_o,
  output logic [31:0]              slv_addr_o,
  output logic [31:0]              slv_data_o,
  input  logic [32*NUM_SLAVES-1:0] slv_data_i,
  input  logic [NUM_SLAVES-1:0]    slv_ack_i
);
  localparam int SW = NUM_SLAVES > 1 ? $clog2(NUM_SLAVES) : 1;
  localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2;
  logic [1:0]            state;
  logic [SW-1:0]         sel, idx;
  logic                  hit, op_rd, err;
  logic [7:0]            cnt;
  logic [NUM_SLAVES-1:0] onehot;
  logic [31:0]           rd_word;
  // Address decode: scanning downward lets the lowest matching index win
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--)
      if (proc_addr_i[31:28] == SLAVE_BASE[4*i +: 4]) begin
        hit = 1'b1;
        idx = SW'(i);
      end
  end
  assign onehot      = NUM_SLAVES'(1) << sel;
  assign rd_word     = slv_data_i[32*sel +: 32];
  assign slv_rd_en_o = (state == ACCESS && op_rd) ? onehot : '0;
  assign slv_wr_en_o = (state == ACCESS && !op_rd) ? onehot : '0;
  assign proc_ack_o  = state == RESP;
  assign proc_err_o  = state == RESP && err;
  assign proc_busy_o = state != IDLE;
  // Transaction FSM: latch request, wait for selected ack or timeout, one-cycle response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sel         <= '0;
      op_rd       <= 1'b0;
      err         <= 1'b0;
      cnt         <= '0;
      slv_addr_o  <= '0;
      slv_data_o  <= '0;
      proc_data_o <= '0;
    end else begin
      case (state)
        IDLE:
          if (proc_rd_en_i ^ proc_wr_en_i) begin
            slv_addr_o <= proc_addr_i;
            slv_data_o <= proc_data_i;
            op_rd      <= proc_rd_en_i;
            sel        <= idx;
            err        <= !hit;
            cnt        <= '0;
            state      <= hit ? ACCESS : RESP;
            if (!hit && proc_rd_en_i) proc_data_o <= ERR_DATA;
          end else if (proc_rd_en_i && proc_wr_en_i) begin
            err         <= 1'b1;
            proc_data_o <= ERR_DATA;
            state       <= RESP;
          end
        ACCESS:
          if (slv_ack_i[sel]) begin
            err   <= 1'b0;
            state <= RESP;
            if (op_rd) proc_data_o <= rd_word;
          end else if (cnt == 8'(TIMEOUT - 1)) begin
            err   <= 1'b1;
            state <= RESP;
            if (op_rd) proc_data_o <= ERR_DATA;
          end else begin
            cnt <= cnt + 8'd1;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_interconnect_n.sv
// tb_bus_interconnect_n: directed stimulus with a transaction-timeline model checked every cycle
module tb_bus_interconnect_n;
  localparam int TMO = 16;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        rd = 1'b0, wr = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] proc_data_o, slv_addr_o, slv_data_o;
  logic        proc_ack_o, proc_err_o, proc_busy_o;
  logic [1:0]  slv_rd_en_o, slv_wr_en_o, slv_ack_i;
  logic [63:0] slv_data_i;
  int          w[2] = '{0, 0};
  int          scnt[2] = '{0, 0};
  logic [1:0]  noise = 2'b00;
  logic [31:0] rdata[2] = '{32'h0, 32'h0};
  int          checks = 0, errors = 0;
  int          cyc = 0, m_start = 0, m_acc_lo = 1, m_acc_hi = 0, m_resp = -1, m_sel = 0;
  logic        m_rd = 1'b0, m_err = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_prev = '0, m_new = '0;
  int          en_cyc = 0, ack_cnt = 0;
  logic        ack_err = 1'b0;
  int          base[2] = '{0, 8};

  bus_interconnect_n dut (
    .clk(clk), .rst_n(rst_n), .proc_rd_en_i(rd), .proc_wr_en_i(wr),
    .proc_addr_i(addr), .proc_data_i(wdata), .proc_data_o(proc_data_o),
    .proc_ack_o(proc_ack_o), .proc_err_o(proc_err_o), .proc_busy_o(proc_busy_o),
    .slv_rd_en_o(slv_rd_en_o), .slv_wr_en_o(slv_wr_en_o), .slv_addr_o(slv_addr_o),
    .slv_data_o(slv_data_o), .slv_data_i(slv_data_i), .slv_ack_i(slv_ack_i)
  );

  always #5 clk = ~clk;

  // Slave models: ack on the w-th enabled cycle (w<0 never), optional stray ack noise
  assign slv_data_i = {rdata[1], rdata[0]};
  always_comb
    for (int i = 0; i < 2; i++)
      slv_ack_i[i] = noise[i] | ((slv_rd_en_o[i] | slv_wr_en_o[i]) && w[i] >= 0 && scnt[i] == w[i]);
  always @(posedge clk)
    for (int i = 0; i < 2; i++) scnt[i] <= (slv_rd_en_o[i] | slv_wr_en_o[i]) ? scnt[i] + 1 : 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", n, cyc, act, exp);
    end
  endtask

  // Model: on acceptance, compute the whole transaction timeline from the slave wait and timeout rules
  always @(posedge clk) begin
    if (!rst_n) begin
      m_start = 0; m_acc_lo = 1; m_acc_hi = 0; m_resp = -1;
      m_prev = '0; m_new = '0; m_addr = '0; m_wdata = '0;
    end else if (cyc > m_resp && (rd || wr)) begin
      m_prev = m_new;
      m_start = cyc + 1;
      m_acc_lo = 1; m_acc_hi = 0;
      if (rd && wr) begin
        m_err = 1'b1; m_resp = cyc + 1; m_new = ERR;
      end else begin
        m_addr = addr; m_wdata = wdata; m_rd = rd; m_sel = -1;
        for (int i = 0; i < 2; i++) if (m_sel < 0 && int'(addr[31:28]) == base[i]) m_sel = i;
        if (m_sel < 0) begin
          m_sel = 0; m_err = 1'b1; m_resp = cyc + 1; m_new = rd ? ERR : m_prev;
        end else begin
          m_err = !(w[m_sel] >= 0 && w[m_sel] < TMO);
          m_acc_lo = cyc + 1;
          m_acc_hi = cyc + (m_err ? TMO : w[m_sel] + 1);
          m_resp = m_acc_hi + 1;
          m_new = !rd ? m_prev : m_err ? ERR : rdata[m_sel];
        end
      end
    end
    cyc++;
  end

  // Per-cycle comparison of every output against the model, plus observation counters
  always @(negedge clk) begin
    logic [1:0] e;
    e = (cyc >= m_acc_lo && cyc <= m_acc_hi) ? 2'(2'b01 << m_sel) : 2'b00;
    if (!rst_n) begin
      chk("rst_rd_en", 32'(slv_rd_en_o), 0); chk("rst_wr_en", 32'(slv_wr_en_o), 0);
      chk("rst_ack", 32'(proc_ack_o), 0); chk("rst_err", 32'(proc_err_o), 0);
      chk("rst_busy", 32'(proc_busy_o), 0); chk("rst_data", proc_data_o, 0);
      chk("rst_addr", slv_addr_o, 0); chk("rst_wdata", slv_data_o, 0);
    end else begin
      chk("rd_en", 32'(slv_rd_en_o), 32'(m_rd ? e : 2'b00));
      chk("wr_en", 32'(slv_wr_en_o), 32'(m_rd ? 2'b00 : e));
      chk("ack", 32'(proc_ack_o), 32'(cyc == m_resp));
      chk("err", 32'(proc_err_o), 32'(cyc == m_resp && m_err));
      chk("busy", 32'(proc_busy_o), 32'(cyc >= m_start && cyc <= m_resp));
      chk("data", proc_data_o, cyc >= m_resp ? m_new : m_prev);
      chk("slv_addr", slv_addr_o, m_addr);
      chk("slv_data", slv_data_o, m_wdata);
    end
    if (|(slv_rd_en_o | slv_wr_en_o)) en_cyc++;
    if (proc_ack_o) begin ack_cnt++; ack_err = proc_err_o; end
  end

  task automatic wait_idle();
    int n = 0;
    while (proc_busy_o && n < 64) begin @(negedge clk); n++; end
    if (proc_busy_o) begin
      errors++;
      $display("FAIL wait_idle busy still high after %0d cycles", n);
    end
  endtask

  task automatic req(input logic r, input logic wv, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    en_cyc = 0; rd = r; wr = wv; addr = a; wdata = d;
    @(posedge clk); #1;
    rd = 0; wr = 0;
    @(negedge clk);
    wait_idle();
  endtask

  initial begin
    int acks;
    rdata[1] = 32'h1234_5678;
    rdata[0] = 32'hCAFE_0000;
    repeat (2) @(negedge clk);
    chk("lit_reset_data", proc_data_o, 32'h0);
    chk("lit_reset_busy", 32'(proc_busy_o), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    w[1] = 0;
    req(1, 0, 32'h8000_0004, 0);
    chk("lit_rd1_data", proc_data_o, 32'h1234_5678);
    chk("lit_rd1_en", en_cyc, 1);
    chk("lit_rd1_err", 32'(ack_err), 0);
    w[0] = 3;
    req(0, 1, 32'h0000_0010, 32'hA5A5_A5A5);
    chk("lit_wr_en", en_cyc, 4);
    chk("lit_wr_wdata", slv_data_o, 32'hA5A5_A5A5);
    chk("lit_wr_data", proc_data_o, 32'h1234_5678);
    req(1, 0, 32'h4000_0000, 0);
    chk("lit_unm_en", en_cyc, 0);
    chk("lit_unm_err", 32'(ack_err), 1);
    chk("lit_unm_data", proc_data_o, 32'hDEAD_BEEF);
    w[0] = 0;
    req(1, 0, 32'h0000_0020, 0);
    chk("lit_rd0_data", proc_data_o, 32'hCAFE_0000);
    w[1] = -1;
    req(1, 0, 32'h8000_0000, 0);
    chk("lit_tmo_en", en_cyc, 16);
    chk("lit_tmo_err", 32'(ack_err), 1);
    chk("lit_tmo_data", proc_data_o, 32'hDEAD_BEEF);
    w[1] = 15; noise[0] = 1'b1;
    req(1, 0, 32'h8000_0008, 0);
    chk("lit_edge_en", en_cyc, 16);
    chk("lit_edge_err", 32'(ack_err), 0);
    chk("lit_edge_data", proc_data_o, 32'h1234_5678);
    noise[0] = 1'b0;
    req(1, 1, 32'h0000_0000, 0);
    chk("lit_both_en", en_cyc, 0);
    chk("lit_both_err", 32'(ack_err), 1);
    chk("lit_both_data", proc_data_o, 32'hDEAD_BEEF);
    w[1] = 2; acks = ack_cnt;
    @(posedge clk); #1 rd = 1; addr = 32'h8000_0000;
    repeat (12) @(posedge clk);
    #1 rd = 0;
    @(negedge clk);
    wait_idle();
    chk("lit_b2b_acks", ack_cnt - acks, 3);
    w[1] = -1; acks = ack_cnt;
    @(posedge clk); #1 rd = 1; addr = 32'h8000_0000;
    @(posedge clk); #1 rd = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("lit_mid_rst_busy", 32'(proc_busy_o), 0);
    chk("lit_mid_rst_en", 32'(slv_rd_en_o), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("lit_mid_rst_idle", 32'(proc_busy_o), 0);
    chk("lit_mid_rst_noack", ack_cnt - acks, 0);
    w[1] = 0;
    req(1, 0, 32'h8000_0000, 0);
    chk("lit_recover_data", proc_data_o, 32'h1234_5678);
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bus_interconnect_n.md
BUS_INTERCONNECT_N -- requirements
Module: bus_interconnect_n

Interface
REQ-001 The block SHALL have parameter NUM_SLAVES, default 2, number of slave ports, legal range 1..8.
REQ-002 The block SHALL have parameter SLAVE_BASE, default {4'h8,4'h0}, a packed 4*NUM_SLAVES-bit field; nibble i is the addr[31:28] region of slave i.
REQ-003 The block SHALL have parameter TIMEOUT, default 16, the number of cycles to wait for slave ack before an error, legal range 1..255.
REQ-004 The block SHALL have parameter ERR_DATA, default 32'hDEAD_BEEF, the read data returned on error.
REQ-005 The block SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst_n  in  1  the asynchronous, active-low reset.
REQ-007 The block SHALL have port proc_rd_en_i  in  1  the read request.
REQ-008 The block SHALL have port proc_wr_en_i  in  1  the write request.
REQ-009 The block SHALL have port proc_addr_i  in  32  the request address.
REQ-010 The block SHALL have port proc_data_i  in  32  the write data.
REQ-011 The block SHALL have port proc_data_o  out  32  the registered read data.
REQ-012 The block SHALL have port proc_ack_o  out  1  a one-cycle completion pulse.
REQ-013 The block SHALL have port proc_err_o  out  1  an error flag, valid when proc_ack_o=1.
REQ-014 The block SHALL have port proc_busy_o  out  1  high while a transaction is outstanding.
REQ-015 The block SHALL have port slv_rd_en_o  out  NUM_SLAVES  the per-slave read enables.
REQ-016 The block SHALL have port slv_wr_en_o  out  NUM_SLAVES  the per-slave write enables.
REQ-017 The block SHALL have port slv_addr_o  out  32  the latched address, broadcast to all slaves.
REQ-018 The block SHALL have port slv_data_o  out  32  the latched write data, broadcast to all slaves.
REQ-019 The block SHALL have port slv_data_i  in  32*NUM_SLAVES  the read data; slave i is on bits [32i+31:32i].
REQ-020 The block SHALL have port slv_ack_i  in  NUM_SLAVES  the per-slave completion; may be held high (zero-wait slave).

Function
REQ-021 Decode: the block SHALL select slave i when proc_addr_i[31:28] equals nibble i of SLAVE_BASE; if several nibbles match, the lowest index wins; if none match, the address is unmapped.
REQ-022 The FSM SHALL have states IDLE, ACCESS and RESP; the reset state is IDLE.
REQ-023 In IDLE, when exactly one of proc_rd_en_i/proc_wr_en_i is sampled high, the block SHALL latch the address, write data, operation and decoded index.
- Mapped address: next state ACCESS.
- Unmapped address: next state RESP with error set.
REQ-024 In IDLE, when both proc_rd_en_i and proc_wr_en_i are sampled high, the block SHALL latch nothing and go to RESP with error set; proc_data_o=ERR_DATA.
REQ-025 In ACCESS, the block SHALL drive only the selected bit of slv_rd_en_o or slv_wr_en_o high (per the latched operation), hold every other enable bit at 0, and drive slv_addr_o/slv_data_o from the latches.
REQ-026 In ACCESS, when slv_ack_i[sel] is sampled high, the block SHALL deassert the enable the next cycle, capture slv_data_i[sel] into proc_data_o (reads only; writes leave proc_data_o unchanged), and go to RESP with error clear.
REQ-027 In ACCESS, acks from unselected slaves SHALL be ignored.
REQ-028 Timeout: an 8-bit counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without ack; when it reaches TIMEOUT-1 with no ack, the block SHALL go to RESP with error set, proc_data_o=ERR_DATA for reads, and the enable dropped.
REQ-029 An ack arriving in the same cycle the counter reaches TIMEOUT-1 SHALL win: success, no error.
REQ-030 RESP SHALL last exactly one cycle with proc_ack_o=1 and proc_err_o as latched, then return to IDLE.
REQ-031 proc_busy_o SHALL be 1 in ACCESS and RESP and 0 in IDLE.
REQ-032 Requests presented while busy SHALL be ignored and not queued; after RESP the block SHALL accept a new request in the IDLE cycle.
REQ-033 Latency: request sampled at edge 0 -> enable high in cycle 1 -> zero-wait ack sampled at edge 1 -> proc_ack_o high in cycle 2; minimum 3 cycles per transaction, including the IDLE cycle.
REQ-034 proc_data_o SHALL hold its last value until the next read completion or read error.

Reset
REQ-035 When rst_n=0 (asynchronous), the block SHALL reset: state=IDLE; proc_data_o=0; proc_ack_o=0; proc_err_o=0; proc_busy_o=0; all slv_*_en_o=0; slv_addr_o=0; slv_data_o=0; timeout counter=0.
REQ-036 A reset mid-transaction SHALL abandon the transaction with no ack pulse; the first cycle after release SHALL be IDLE.

Verification
REQ-037 Read at 0x8000_0004, slave 1 acks in the first ACCESS cycle with 0x1234_5678 -> slv_rd_en_o=2'b10 for 1 cycle; proc_ack_o in cycle 2; proc_data_o=0x1234_5678; proc_err_o=0.
REQ-038 Write 0xA5A5_A5A5 to 0x0000_0010, slave 0 acks after 3 wait cycles -> slv_wr_en_o[0] high for 4 cycles with slv_data_o=0xA5A5_A5A5; ack with no error; proc_data_o unchanged.
REQ-039 Read 0x4000_0000 (unmapped) -> no slave enable; proc_ack_o in the cycle after the request; proc_err_o=1; proc_data_o=0xDEAD_BEEF.
REQ-040 Read slave 1, which never acks, with TIMEOUT=16 -> enable high for 16 cycles, then proc_ack_o=1, proc_err_o=1, proc_data_o=ERR_DATA; the next request is accepted normally.
REQ-041 Both rd and wr high -> error response with no enables; a new request during ACCESS is ignored; rst_n pulsed low mid-ACCESS -> all outputs 0, no ack, IDLE after release.
